fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0, first fetch address after reset.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 RST  in  1  asynchronous active-low reset.
REQ-005 freeze  in  1  hazard stall from decode; output register must hold.
REQ-006 Branch_taken  in  1  redirect request, valid for one cycle.
REQ-007 Branch_Address  in  32  redirect target; sampled when Branch_taken=1.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  address of the outstanding request.
REQ-010 imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req.
REQ-011 imem_rdata  in  32  instruction word; valid when imem_ack=1.
REQ-012 Instruction  out  32  registered instruction to decode.
REQ-013 PC  out  32  registered address of Instruction plus 4.
REQ-014 valid  out  1  Instruction/PC hold a live instruction.

Function
REQ-015 State: fetch_pc (next address to fetch); FSM {RUN, DROP}; output register O = {Instruction, PC, valid}; one-entry skid S = {s_instr, s_pc, s_valid}.
REQ-016 imem_req SHALL be 1 when (state=RUN and s_valid=0) or state=DROP; otherwise 0.
REQ-017 While imem_req=1 and imem_ack=0, imem_addr SHALL hold the same value.
REQ-018 In RUN, imem_addr SHALL equal fetch_pc.
REQ-019 Accepted response = imem_ack=1 in RUN with imem_req=1; on acceptance fetch_pc SHALL become fetch_pc+4 (mod 2^32 wrap).
REQ-020 advance = (freeze=0) or (valid=0).
REQ-021 If advance and s_valid=1: O SHALL load S with valid=1, and s_valid SHALL clear.
REQ-022 Else if advance and accepted response: O SHALL load {imem_rdata, imem_addr+4, 1}.
REQ-023 Else if advance: valid SHALL become 0; Instruction and PC hold.
REQ-024 If advance=0 and accepted response: S SHALL load {imem_rdata, imem_addr+4}, s_valid=1; O holds.
REQ-025 Since imem_req=0 while s_valid=1, an accepted response and s_valid=1 SHALL never coincide; no instruction is lost or duplicated.
REQ-026 Branch_taken=1 SHALL take priority over freeze and all other events: next cycle valid=0, s_valid=0, and fetch_pc=Branch_Address.
REQ-027 Branch_taken in RUN with imem_req=1 and imem_ack=0: next state DROP, and imem_addr keeps the old address.
REQ-028 Branch_taken in RUN with no outstanding request, or with imem_ack=1 in the same cycle: ack data discarded; next state RUN; imem_addr=Branch_Address.
REQ-029 In DROP: imem_ack=1 data SHALL be discarded, with next state RUN and imem_addr=fetch_pc; a further Branch_taken SHALL update fetch_pc only.
REQ-030 Latency: an instruction acked in cycle N SHALL appear on O in cycle N+1 when advance=1 in cycle N.

Reset
REQ-031 RST=0 SHALL immediately force: state=RUN, fetch_pc=RESET_PC, Instruction=0, PC=0, valid=0, s_valid=0, s_instr=0, s_pc=0.
REQ-032 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
REQ-033 Reset asserted mid-request SHALL abandon the request without waiting for imem_ack.

Verification
REQ-034 Reset release, ack every cycle, rdata=addr -> Instruction 0,4,8 with PC 4,8,12 and valid=1 from the cycle after the first ack.
REQ-035 Ack delayed 3 cycles -> imem_req=1 and imem_addr=0 stable for 3 cycles; valid=0 until the cycle after ack; then Instruction=0, PC=4.
REQ-036 freeze=1 for 2 cycles while holding addr 8 and ack for 0xC arrives -> O holds 8; S=0xC; imem_req=0; after freeze drops, O=0xC then 0x10, with no gap beyond one cycle and no duplicate.
REQ-037 Request for 0x20 pending, Branch_taken with 0x100 -> DROP; imem_addr stays 0x20 until ack; data discarded; next imem_addr=0x100; valid=0 until the 0x100 instruction arrives.
REQ-038 Branch_taken and freeze both 1 with S full -> next cycle valid=0, s_valid=0, fetch_pc=Branch_Address.
REQ-039 RST pulsed low mid-wait with imem_addr=0x40 -> all outputs reset asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: instruction fetch with one-entry skid and branch redirect.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        valid
);

  typedef enum logic [0:0] {RUN = 1'b0, DROP = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_s_instr;
  logic [31:0] r_s_pc;
  logic        r_s_valid;
  logic        w_accept;
  logic        w_advance;
  logic [31:0] w_next_pc;

  // DROP keeps presenting the abandoned address until memory answers it.
  assign imem_req  = (r_state == DROP) || !r_s_valid;
  assign imem_addr = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
  assign w_advance = !freeze || !valid;
  assign w_accept  = (r_state == RUN) && imem_req && imem_ack && !Branch_taken;
  assign w_next_pc = imem_addr + 32'd4;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= RUN;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (Branch_taken && imem_req && !imem_ack) w_next_state = DROP;
      DROP:    if (imem_ack) w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_drop_addr <= 32'h0;
    end else if (r_state == RUN && Branch_taken && imem_req && !imem_ack) begin
      r_drop_addr <= r_fetch_pc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fetch_pc  <= RESET_PC;
      Instruction <= 32'h0;
      PC          <= 32'h0;
      valid       <= 1'b0;
      r_s_instr   <= 32'h0;
      r_s_pc      <= 32'h0;
      r_s_valid   <= 1'b0;
    end else if (Branch_taken) begin
      r_fetch_pc <= Branch_Address;
      valid      <= 1'b0;
      r_s_valid  <= 1'b0;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_advance && r_s_valid) begin
        Instruction <= r_s_instr;
        PC          <= r_s_pc;
        valid       <= 1'b1;
        r_s_valid   <= 1'b0;
      end else if (w_advance && w_accept) begin
        Instruction <= imem_rdata;
        PC          <= w_next_pc;
        valid       <= 1'b1;
      end else if (w_advance) begin
        valid <= 1'b0;
      end else if (w_accept) begin
        // Decode is stalled: park the response so it is neither lost nor refetched.
        r_s_instr <= imem_rdata;
        r_s_pc    <= w_next_pc;
        r_s_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit: directed self-checking bench for fetch_unit.              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] Branch_Address = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        valid;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .freeze(freeze), .Branch_taken(Branch_taken),
    .Branch_Address(Branch_Address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instruction(Instruction),
    .PC(PC), .valid(valid)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    RST = 1'b1;
  endtask

  // Memory answers immediately with rdata equal to the address, n times.
  task automatic feed(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'b1; imem_rdata = start + 32'(4 * i);
      tick();
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid); end
    checks++; if (Instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", Instruction); end
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC); end
    RST = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e = 32'(4 * i);
      checks++; if (imem_addr !== e) begin failures++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, e); end
      imem_ack = 1'b1; imem_rdata = e;
      tick();
      checks++; if (Instruction !== e) begin failures++; $display("FAIL stream_instr got=%h exp=%h", Instruction, e); end
      checks++; if (PC !== e + 32'd4) begin failures++; $display("FAIL stream_pc got=%h exp=%h", PC, e + 32'd4); end
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stream_valid got=%0h exp=1", valid); end
    end
    imem_ack = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL stream_bubble got=%0h exp=0", valid); end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL delay_hold got req=%0h addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL delay_valid got=%0h exp=0", valid); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0;
    checks++; if (valid !== 1'b1 || Instruction !== 32'h0 || PC !== 32'h4) begin failures++; $display("FAIL delay_out got v=%0h i=%h pc=%h exp v=1 i=0 pc=4", valid, Instruction, PC); end
  endtask

  task automatic test_freeze();
    do_reset();
    feed(32'h0, 3);
    checks++; if (Instruction !== 32'h8 || imem_addr !== 32'hC) begin failures++; $display("FAIL frz_setup got i=%h addr=%h exp i=8 addr=c", Instruction, imem_addr); end
    freeze = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hC;
    tick();
    checks++; if (Instruction !== 32'h8 || PC !== 32'hC || valid !== 1'b1) begin failures++; $display("FAIL frz_hold1 got i=%h pc=%h v=%0h exp i=8 pc=c v=1", Instruction, PC, valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL frz_req got=%0h exp=0", imem_req); end
    imem_rdata = 32'hBAD;
    tick();
    checks++; if (Instruction !== 32'h8 || imem_req !== 1'b0) begin failures++; $display("FAIL frz_hold2 got i=%h req=%0h exp i=8 req=0", Instruction, imem_req); end
    freeze = 1'b0; imem_ack = 1'b0;
    tick();
    checks++; if (Instruction !== 32'hC || PC !== 32'h10 || valid !== 1'b1) begin failures++; $display("FAIL frz_skid got i=%h pc=%h v=%0h exp i=c pc=10 v=1", Instruction, PC, valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL frz_next got req=%0h addr=%h exp req=1 addr=10", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h10;
    tick();
    imem_ack = 1'b0;
    checks++; if (Instruction !== 32'h10 || PC !== 32'h14 || valid !== 1'b1) begin failures++; $display("FAIL frz_after got i=%h pc=%h v=%0h exp i=10 pc=14 v=1", Instruction, PC, valid); end
  endtask

  task automatic test_branch_drop();
    do_reset();
    feed(32'h0, 8);
    checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL drop_setup got=%h exp=20", imem_addr); end
    Branch_taken = 1'b1; Branch_Address = 32'h100;
    tick();
    Branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || valid !== 1'b0) begin failures++; $display("FAIL drop_enter got req=%0h addr=%h v=%0h exp req=1 addr=20 v=0", imem_req, imem_addr, valid); end
    tick();
    checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL drop_hold got=%h exp=20", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD;
    tick();
    checks++; if (valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin failures++; $display("FAIL drop_exit got v=%0h addr=%h req=%0h exp v=0 addr=100 req=1", valid, imem_addr, imem_req); end
    imem_rdata = 32'hAAA;
    tick();
    imem_ack = 1'b0;
    checks++; if (Instruction !== 32'hAAA || PC !== 32'h104 || valid !== 1'b1) begin failures++; $display("FAIL drop_target got i=%h pc=%h v=%0h exp i=aaa pc=104 v=1", Instruction, PC, valid); end
  endtask

  task automatic test_branch_freeze();
    do_reset();
    feed(32'h0, 1);
    freeze = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h4;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bf_skid got req=%0h exp=0", imem_req); end
    imem_ack = 1'b0; Branch_taken = 1'b1; Branch_Address = 32'h200;
    tick();
    Branch_taken = 1'b0;
    checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL bf_branch got v=%0h req=%0h addr=%h exp v=0 req=1 addr=200", valid, imem_req, imem_addr); end
    freeze = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h55;
    tick();
    imem_ack = 1'b0;
    checks++; if (Instruction !== 32'h55 || PC !== 32'h204 || valid !== 1'b1) begin failures++; $display("FAIL bf_after got i=%h pc=%h v=%0h exp i=55 pc=204 v=1", Instruction, PC, valid); end
  endtask

  task automatic test_branch_ack_wrap();
    do_reset();
    feed(32'h0, 2);
    imem_ack = 1'b1; imem_rdata = 32'h8; Branch_taken = 1'b1; Branch_Address = 32'hFFFF_FFFC;
    tick();
    Branch_taken = 1'b0;
    checks++; if (valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL ba_redirect got v=%0h addr=%h exp v=0 addr=fffffffc", valid, imem_addr); end
    imem_rdata = 32'h77;
    tick();
    imem_ack = 1'b0;
    checks++; if (Instruction !== 32'h77 || PC !== 32'h0 || valid !== 1'b1) begin failures++; $display("FAIL ba_wrap_out got i=%h pc=%h v=%0h exp i=77 pc=0 v=1", Instruction, PC, valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL ba_wrap_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    feed(32'h0, 16);
    checks++; if (imem_addr !== 32'h40 || valid !== 1'b1) begin failures++; $display("FAIL ar_setup got addr=%h v=%0h exp addr=40 v=1", imem_addr, valid); end
    #2 RST = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || Instruction !== 32'h0 || PC !== 32'h0) begin failures++; $display("FAIL ar_outs got v=%0h i=%h pc=%h exp all 0", valid, Instruction, PC); end
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL ar_addr got addr=%h req=%0h exp addr=0 req=1", imem_addr, imem_req); end
    tick();
    RST = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL ar_release got addr=%h req=%0h exp addr=0 req=1", imem_addr, imem_req); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_delayed_ack();
    test_freeze();
    test_branch_drop();
    test_branch_freeze();
    test_branch_ack_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
